instr_encoder_loader: RTL and testbench

- Encoder counterpart to the single-cycle RV32I control unit: turns symbolic instruction records (kind, rd, rs1, rs2, imm) into 32-bit RV32I words.
- Writes the words sequentially into instruction memory, so test programs for the single-cycle core can be built in simulation without a hex file.
- Sits between a bench or boot sequencer (valid/ready record stream) and the instruction-memory write port.

---
 rtl/instr_encoder_loader.sv | 90 +++++++++
 tb/tb_instr_encoder_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I instruction records into sequential imem writes; define ENC_CHECK_EN to enable immediate-range field checks
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] count,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
  state_t state, state_n;
  logic [ADDR_W-1:0] ctr;
  logic [31:0] enc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic acc, ovf, chk_err;
  assign in_ready = state == LOAD;
  assign done = state == DONE;
  assign acc = in_valid && in_ready;
  assign ovf = ctr == LAST_ADDR && !in_last;
`ifdef ENC_CHECK_EN
  assign chk_err = (kind == 3'd7 && imm[0]) || (kind <= 3'd1 && imm[12] != imm[11]);
`else
  logic unused_imm0;
  assign unused_imm0 = imm[0];
  assign chk_err = 1'b0;
`endif
  // instruction word for the presented record
  always_comb begin
    f3 = kind == 3'd4 ? 3'b111 : kind == 3'd5 ? 3'b110 : kind == 3'd6 ? 3'b010 : 3'b000;
    f7 = kind == 3'd3 ? 7'b0100000 : 7'b0000000;
    enc = kind == 3'd0 ? {imm[11:0], rs1, 3'b010, rd, 7'b0000011} :
          kind == 3'd1 ? {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011} :
          kind == 3'd7 ? {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011} :
                         {f7, rs2, rs1, f3, rd, 7'b0110011};
  end
  // next state: DONE after the last record or the top-of-memory write, then back to IDLE
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? LOAD : IDLE;
    else if (state == LOAD) state_n = acc && (in_last || ovf) ? DONE : LOAD;
    else state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // write port, address counter, word count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we <= 1'b0;
      imem_addr <= BASE;
      imem_wdata <= '0;
      ctr <= BASE;
      count <= '0;
      err <= 1'b0;
    end else begin
      imem_we <= acc;
      if (state == IDLE && start) begin
        ctr <= BASE;
        count <= '0;
        err <= 1'b0;
      end
      if (acc) begin
        imem_addr <= ctr;
        imem_wdata <= enc;
        ctr <= ctr + ADDR_W'(4);
        count <= count + ADDR_W'(1);
        if (ovf || chk_err) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed bench for instr_encoder_loader (default width and ADDR_W=4 instances)
module tb_instr_encoder_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
  logic [2:0] kind = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [12:0] imm = 0;
  logic in_ready, imem_we, done, err;
  logic [7:0] imem_addr, count;
  logic [31:0] imem_wdata;
  logic in_ready4, we4, done4, err4;
  logic [3:0] addr4, count4;
  logic [31:0] wdata4;
  int checks = 0, errors = 0;
`ifdef ENC_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif
  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err(err)
  );
  instr_encoder_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_last(in_last), .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
    .count(count4), .done(done4), .err(err4)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [12:0] im, input logic last);
    in_valid = 1; kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = last;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_we", imem_we, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", count, 0);
    rst_n = 1;
    pulse_start();
    check("load_ready", in_ready, 1);
    send(3'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1);
    tick();
    in_valid = 0;
    check("lw_we", imem_we, 1);
    check("lw_addr", imem_addr, 8'h00);
    check("lw_wdata", imem_wdata, 32'h00812283);
    check("lw_done", done, 1);
    check("lw_count", count, 1);
    check("lw_ready_drop", in_ready, 0);
    tick();
    check("lw_we_end", imem_we, 0);
    check("lw_done_end", done, 0);
    check("lw_idle_ready", in_ready, 0);
    pulse_start();
    send(3'd1, 5'd0, 5'd3, 5'd6, 13'd12, 0);
    tick();
    check("sw_we", imem_we, 1);
    check("sw_addr", imem_addr, 8'h00);
    check("sw_wdata", imem_wdata, 32'h0061A623);
    check("sw_done", done, 0);
    send(3'd3, 5'd1, 5'd2, 5'd3, 13'd0, 0);
    tick();
    check("sub_we", imem_we, 1);
    check("sub_addr", imem_addr, 8'h04);
    check("sub_wdata", imem_wdata, 32'h403100B3);
    send(3'd7, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1);
    tick();
    in_valid = 0;
    check("beq_we", imem_we, 1);
    check("beq_addr", imem_addr, 8'h08);
    check("beq_wdata", imem_wdata, 32'hFE208EE3);
    check("beq_done", done, 1);
    check("beq_count", count, 3);
    tick();
    check("b2b_we_end", imem_we, 0);
    pulse_start();
    send(3'd2, 5'd1, 5'd2, 5'd3, 13'd0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ovf_we4", we4, 1);
      check("ovf_addr4", addr4, 4 * i);
      check("ovf_wdata4", wdata4, 32'h003100B3);
      check("cont_addr", imem_addr, 4 * i);
      start = i == 1;
    end
    start = 0;
    check("ovf_err4", err4, 1);
    check("ovf_done4", done4, 1);
    check("ovf_ready4", in_ready4, 0);
    check("ovf_count4", count4, 4);
    check("cont_err", err, 0);
    tick();
    check("ovf_no5th", we4, 0);
    check("ovf_done4_end", done4, 0);
    check("ovf_err4_sticky", err4, 1);
    check("ign_start_we", imem_we, 1);
    check("ign_start_addr", imem_addr, 8'h10);
    check("ign_start_count", count, 5);
    tick();
    check("pre_rst_addr", imem_addr, 8'h14);
    check("pre_rst_we", imem_we, 1);
    rst_n = 0;
    #1;
    check("arst_we", imem_we, 0);
    check("arst_count", count, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_ready", in_ready, 0);
    check("arst_err4", err4, 0);
    in_valid = 0;
    tick();
    check("arst_hold_we", imem_we, 0);
    tick();
    rst_n = 1;
    pulse_start();
    send(3'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1);
    tick();
    in_valid = 0;
    check("restart_addr", imem_addr, 8'h00);
    check("restart_we", imem_we, 1);
    check("restart_count", count, 1);
    tick();
    pulse_start();
    send(3'd7, 5'd0, 5'd1, 5'd2, 13'h003, 1);
    tick();
    in_valid = 0;
    check("chk_we", imem_we, 1);
    check("chk_wdata", imem_wdata, 32'h00208163);
    check("chk_err", err, EXP_CHK);
    tick();
    check("chk_err_sticky", err, EXP_CHK);
    pulse_start();
    check("start_clears_err", err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
